rgb_loader: RTL and testbench
=============================

RGB_LOADER -- requirements
Module: rgb_loader

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port c  input  5  hundreds digit from digit memory; 0-9 valid, 16 = blank.
REQ-004 SHALL have port d  input  5  tens digit, same encoding as c.
REQ-005 SHALL have port u  input  5  units digit, same encoding as c.
REQ-006 SHALL have port RGB_full  input  1  high while all three digits are non-blank.
REQ-007 SHALL have port clr_digits  output  1  one-cycle pulse; drives the digit memory's reset.
REQ-008 SHALL have ports r, g, b  output  8 each  stored channel intensities.
REQ-009 SHALL have port ch  output  2  next channel to load: 0=R, 1=G, 2=B; 3 is never driven.
REQ-010 SHALL have port busy  output  1  high from capture through the CLEAR state.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a channel is written.
REQ-012 SHALL have port sat  output  1  latched; set when the last written value was clamped.
REQ-013 SHALL have port err  output  1  one-cycle pulse when the number is rejected.

Function
REQ-014 SHALL use FSM states IDLE, MAC1, MAC2, WRITE, CLEAR.
REQ-015 IDLE SHALL detect a rising edge of RGB_full (previous value registered) at edge k.
REQ-016 On that edge it SHALL capture c, d and u into internal registers and go to MAC1.
REQ-017 MAC1 (edge k+1) SHALL compute acc <= c*10 + d, with acc 10 bits wide.
REQ-018 MAC2 (edge k+2) SHALL compute acc <= acc*10 + u; maximum value 999, no overflow.
REQ-019 Each *10 SHALL be implemented as (x<<3)+(x<<1); no multiplier inferred.
REQ-020 WRITE (edge k+3), all digits <=9: target channel <= min(acc,255).
REQ-021 In WRITE, sat SHALL be set to (acc>255).
REQ-022 In WRITE, ch SHALL advance 0->1->2->0.
REQ-023 In WRITE, done=1 and clr_digits=1 for exactly one cycle.
REQ-024 WRITE with any captured digit >9 (codes 10-15, 16): no channel write, ch and sat unchanged.
REQ-025 In that error case err=1 and clr_digits=1 for exactly one cycle.
REQ-026 CLEAR SHALL stay until RGB_full is sampled low, then return to IDLE; busy drops on that edge.
REQ-027 RGB_full rising or toggling while busy=1 SHALL be ignored; captured digits SHALL be frozen from k onward.
REQ-028 Non-target channel registers SHALL hold their value at all times.
REQ-029 RGB_full already high when reset is released SHALL NOT trigger a capture; the edge detector SHALL be primed to 1 by reset.

Reset
REQ-030 On reset: state=IDLE, and r=g=b=0, ch=0, acc=0.
REQ-031 On reset: busy=0, done=0, err=0, sat=0, clr_digits=0, and the edge register=1.
REQ-032 Reset in any state (including mid-MAC) SHALL abort without any channel write or pulse.

Structure
REQ-033 Shared package rgb_pkg SHALL hold the FSM state enum and DIGIT_BLANK=5'd16.
REQ-034 rgb_pkg SHALL also hold CH_R/CH_G/CH_B codes and VAL_MAX=8'd255.
REQ-035 One sub-module, bcd_mac10, SHALL be combinational: (acc_in[9:0], digit[3:0]) -> acc_in*10+digit.
REQ-036 bcd_mac10 SHALL be shared by MAC1 and MAC2.

Verification
REQ-037 Reset, then digits c=1, d=2, u=8 with RGB_full rising at edge k -> r=128 at k+3; done and clr_digits high one cycle; ch=1; sat=0.
REQ-038 Then 2,5,5 -> g=255, sat=0, ch=2; then 9,9,9 -> b=255, sat=1, ch=0 (wrap); r still 128.
REQ-039 Digits 0,0,0 -> current channel=0, done pulses, ch advances.
REQ-040 Digits 1,10,3 -> err pulse and clr_digits at k+3; no done; r/g/b and ch unchanged.
REQ-041 Reset asserted at k+2 (MAC2) with 3,0,0 -> next cycle all outputs 0; no done/clr pulse.
REQ-042 RGB_full held high across WRITE and CLEAR for 5 extra cycles -> exactly one write; busy stays 1 until RGB_full falls.

Source files
------------

// File: rtl/rgb_loader_pkg.sv
// Shared definitions for the RGB loader slice.
//   state_e      : loader FSM states
//   DIGIT_BLANK  : digit-memory code for an empty digit position
//   CH_R/G/B     : channel selector codes (3 is never produced)
//   VAL_MAX      : largest storable channel intensity
//   digit_ok()   : true for a decimal digit 0-9
//   clamp8()     : saturate a 0-999 accumulator to 8 bits
//   next_ch()    : channel rotation R -> G -> B -> R
package rgb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC1,
    S_MAC2,
    S_WRITE,
    S_CLEAR
  } state_e;

  localparam logic [4:0] DIGIT_BLANK = 5'd16;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic [7:0] VAL_MAX = 8'd255;

  function automatic logic digit_ok(input logic [4:0] dig);
    return (dig <= 5'd9);
  endfunction

  function automatic logic [7:0] clamp8(input logic [9:0] v);
    return (v > {2'b00, VAL_MAX}) ? VAL_MAX : v[7:0];
  endfunction

  function automatic logic [1:0] next_ch(input logic [1:0] cur);
    return (cur == CH_B) ? CH_R : cur + 2'd1;
  endfunction

endpackage

// File: rtl/rgb_loader_if.sv
// Digit-memory link of the RGB loader.
//   c, d, u    : hundreds / tens / units digit (0-9 valid, 16 = blank)
//   RGB_full   : high while all three digits are non-blank
//   clr_digits : one-cycle pulse that clears the digit memory
// master = digit memory side, slave = loader side.
interface rgb_loader_if;
  logic [4:0] c;
  logic [4:0] d;
  logic [4:0] u;
  logic       RGB_full;
  logic       clr_digits;

  modport master (
    output c, d, u, RGB_full,
    input  clr_digits
  );

  modport slave (
    input  c, d, u, RGB_full,
    output clr_digits
  );
endinterface

// File: rtl/rgb_loader_bcd_mac10.sv
// Combinational decimal multiply-accumulate: acc_out = acc_in*10 + digit.
//   acc_in  : 10-bit running value
//   digit   : 4-bit digit to append
//   acc_out : 10-bit result (exact for results up to 999)
// The *10 is built from two shifts and an add so no multiplier is inferred.
module bcd_mac10 (
  input  logic [9:0] acc_in,
  input  logic [3:0] digit,
  output logic [9:0] acc_out
);

  always_comb begin
    acc_out = (acc_in << 3) + (acc_in << 1) + {6'b000000, digit};
  end

endmodule

// File: rtl/rgb_loader.sv
// RGB loader: turns a three-digit decimal number from the digit memory into
// an 8-bit intensity for the next colour channel in R -> G -> B order.
//   clk, reset     : clock, synchronous active-high reset
//   dm (slave)     : digits c/d/u, RGB_full in; clr_digits out
//   r, g, b        : stored channel intensities
//   ch             : channel that the next number will load
//   busy           : high from capture until RGB_full is seen low in CLEAR
//   done / err     : one-cycle pulse on channel write / number rejected
//   sat            : latched, set when the last written value was clamped
module rgb_loader
  import rgb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rgb_loader_if.slave        dm,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic [1:0]         ch,
  output logic               busy,
  output logic               done,
  output logic               sat,
  output logic               err
);

  state_e      state_q;
  logic [4:0]  c_q, d_q, u_q;
  logic [9:0]  acc_q;
  logic [9:0]  acc_d;
  logic [9:0]  mac_acc_in;
  logic [3:0]  mac_digit;
  logic        rgb_full_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [1:0]  ch_q;
  logic        busy_q, done_q, sat_q, err_q, clr_q;
  logic        digits_ok;
  logic [7:0]  wr_val;

  // One MAC serves both passes: c*10+d in MAC1, acc*10+u in MAC2.
  always_comb begin
    if (state_q == S_MAC1) begin
      mac_acc_in = {5'b00000, c_q};
      mac_digit  = d_q[3:0];
    end else begin
      mac_acc_in = acc_q;
      mac_digit  = u_q[3:0];
    end
  end

  bcd_mac10 u_mac (
    .acc_in  (mac_acc_in),
    .digit   (mac_digit),
    .acc_out (acc_d)
  );

  // Codes 10-15 and blank wrap through the MAC; the result is discarded
  // because the captured digits are rechecked before any write.
  always_comb begin
    digits_ok = digit_ok(c_q) && digit_ok(d_q) && digit_ok(u_q);
    wr_val    = clamp8(acc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      d_q        <= '0;
      u_q        <= '0;
      acc_q      <= '0;
      rgb_full_q <= 1'b1;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      ch_q       <= CH_R;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      rgb_full_q <= dm.RGB_full;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (dm.RGB_full && !rgb_full_q) begin
            c_q     <= dm.c;
            d_q     <= dm.d;
            u_q     <= dm.u;
            busy_q  <= 1'b1;
            state_q <= S_MAC1;
          end
        end

        S_MAC1: begin
          acc_q   <= acc_d;
          state_q <= S_MAC2;
        end

        S_MAC2: begin
          acc_q   <= acc_d;
          state_q <= S_WRITE;
        end

        S_WRITE: begin
          clr_q   <= 1'b1;
          state_q <= S_CLEAR;
          if (digits_ok) begin
            case (ch_q)
              CH_R:    r_q <= wr_val;
              CH_G:    g_q <= wr_val;
              default: b_q <= wr_val;
            endcase
            sat_q  <= (acc_q > {2'b00, VAL_MAX});
            ch_q   <= next_ch(ch_q);
            done_q <= 1'b1;
          end else begin
            err_q  <= 1'b1;
          end
        end

        S_CLEAR: begin
          if (!dm.RGB_full) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dm.clr_digits = clr_q;
  assign r    = r_q;
  assign g    = g_q;
  assign b    = b_q;
  assign ch   = ch_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sat  = sat_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rgb_loader.sv
// Self-checking bench for rgb_loader: directed scenarios plus randomized
// numbers, compared against a decimal-arithmetic reference model.
module tb_rgb_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r, g, b;
  logic [1:0] ch;
  logic       busy, done, sat, err;

  int passed = 0;
  int total  = 0;

  // Reference model: channel values, next channel, saturation flag.
  int  m_val [3];
  int  m_ch;
  bit  m_sat;

  always #5 clk = ~clk;

  rgb_loader_if dm ();

  rgb_loader dut (
    .clk   (clk),
    .reset (reset),
    .dm    (dm),
    .r     (r),
    .g     (g),
    .b     (b),
    .ch    (ch),
    .busy  (busy),
    .done  (done),
    .sat   (sat),
    .err   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
    m_ch  = 0;
    m_sat = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_r"},   r,   m_val[0]);
    chk({tag, "_g"},   g,   m_val[1]);
    chk({tag, "_b"},   b,   m_val[2]);
    chk({tag, "_ch"},  ch,  m_ch);
    chk({tag, "_sat"}, sat, m_sat);
  endtask

  function automatic int rand_digit();
    if ($urandom_range(0, 9) < 8) return $urandom_range(0, 9);
    return $urandom_range(10, 16);
  endfunction

  // One full transaction: RGB_full rises, digits scrambled and RGB_full
  // toggled during the MAC cycles, held high 'extra' cycles after the write.
  task automatic load(input int cc, input int dd, input int uu, input int extra);
    int  val;
    bit  ok;
    @(negedge clk);
    dm.c = 5'(cc); dm.d = 5'(dd); dm.u = 5'(uu);
    dm.RGB_full = 1'b1;
    @(negedge clk);                                 // after edge k
    chk("k_busy", busy, 1);
    chk("k_done", done, 0);
    dm.c = 5'(rand_digit());
    dm.RGB_full = 1'b0;
    @(negedge clk);                                 // after k+1
    chk("k1_done", done, 0);
    chk("k1_clr", dm.clr_digits, 0);
    dm.d = 5'(rand_digit());
    dm.RGB_full = 1'b1;
    @(negedge clk);                                 // after k+2
    chk("k2_clr", dm.clr_digits, 0);
    chk("k2_err", err, 0);
    dm.u = 5'(rand_digit());

    ok  = (cc <= 9) && (dd <= 9) && (uu <= 9);
    val = 100 * cc + 10 * dd + uu;
    if (ok) begin
      m_val[m_ch] = (val > 255) ? 255 : val;
      m_sat = (val > 255);
      m_ch  = (m_ch + 1) % 3;
    end

    @(negedge clk);                                 // after k+3
    chk("w_done", done, ok ? 1 : 0);
    chk("w_err",  err,  ok ? 0 : 1);
    chk("w_clr",  dm.clr_digits, 1);
    chk("w_busy", busy, 1);
    chk_regs("w");

    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      chk("hold_done", done, 0);
      chk("hold_err",  err,  0);
      chk("hold_clr",  dm.clr_digits, 0);
      chk("hold_busy", busy, 1);
    end
    dm.RGB_full = 1'b0;
    @(negedge clk);
    chk("rel_busy", busy, 0);
    chk_regs("rel");
  endtask

  initial begin
    model_reset();
    // Reset with RGB_full already high: no capture after release.
    reset = 1'b1;
    dm.c = 5'd1; dm.d = 5'd2; dm.u = 5'd3;
    dm.RGB_full = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr",  dm.clr_digits, 0);
    chk("rst_err",  err, 0);
    chk_regs("rst");
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("prime_busy", busy, 0);
      chk("prime_done", done, 0);
    end
    dm.RGB_full = 1'b0;
    @(negedge clk);

    load(1, 2, 8, 1);                   // r = 128
    load(2, 5, 5, 1);                   // g = 255, no sat
    load(9, 9, 9, 1);                   // b = 255, sat, ch wraps
    load(0, 0, 0, 1);                   // r = 0
    load(1, 10, 3, 1);                  // rejected
    load(16, 4, 4, 2);                  // blank digit rejected
    load(0, 4, 2, 5);                   // long hold: single write

    // Reset during MAC2 aborts the transaction.
    @(negedge clk);
    dm.c = 5'd3; dm.d = 5'd0; dm.u = 5'd0;
    dm.RGB_full = 1'b1;
    @(negedge clk);                     // after k
    @(negedge clk);                     // after k+1
    reset = 1'b1;
    model_reset();
    @(negedge clk);                     // after k+2 with reset
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_clr",  dm.clr_digits, 0);
    chk("mid_err",  err, 0);
    chk_regs("mid");
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_clr",  dm.clr_digits, 0);
    end
    chk_regs("post");
    dm.RGB_full = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      load(rand_digit(), rand_digit(), rand_digit(), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
